noc_traffic_node: RTL

NOC_TRAFFIC_NODE -- requirements
Module: noc_traffic_node

---
 rtl/noc_traffic_node.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/noc_traffic_node.sv
// NoC traffic node: generates fixed-format test packets on the sender port and
// checks packets arriving on the receive port, keeping tx/rx/error counters.
//
// TX state | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start
// HEAD     | presenting the header flit, held until handshake
// BODY     | presenting body flit idx_q, held until handshake
// GAP      | idle cycles between packets; parks here while start is low
// DONE     | NUM_PKTS sent, terminal until reset
//
// RX state | meaning
// ---------+--------------------------------------------------------------
// WAIT_HEAD| expecting a header; anything else is counted and dropped
// BODY     | expecting body flit rx_idx_q of the current packet
module noc_traffic_node #(
  parameter int DATA_WIDTH = 32,
  parameter int X_ID       = 0,
  parameter int Y_ID       = 0,
  parameter int DEST_X_ID  = 1,
  parameter int DEST_Y_ID  = 1,
  parameter int MESH_X     = 2,
  parameter int MESH_Y     = 2,
  parameter int MODE       = 0,
  parameter int PKT_LEN    = 4,
  parameter int NUM_PKTS   = 8,
  parameter int GAP        = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst,
  input  logic                  start,
  input  logic                  receive_valid,
  input  logic [DATA_WIDTH-1:0] receive_flit,
  input  logic                  receive_is_header,
  input  logic                  receive_is_tail,
  output logic                  receive_ready,
  output logic                  sender_valid,
  output logic [DATA_WIDTH-1:0] sender_flit,
  output logic                  sender_is_header,
  output logic                  sender_is_tail,
  input  logic                  sender_ready,
  output logic [CNT_W-1:0]      tx_pkt_cnt,
  output logic [CNT_W-1:0]      rx_pkt_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic                  done
);

  localparam logic [3:0]       MX         = 4'(MESH_X);
  localparam logic [3:0]       MY         = 4'(MESH_Y);
  localparam logic [7:0]       SELF_ID    = {4'(Y_ID), 4'(X_ID)};
  localparam logic [7:0]       FIXED_DEST = {4'(DEST_Y_ID), 4'(DEST_X_ID)};
  localparam logic [7:0]       LEN_B      = 8'(PKT_LEN);
  localparam logic [7:0]       LAST_IDX   = 8'(PKT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] NUM_PKTS_C = CNT_W'(NUM_PKTS);
  localparam logic [31:0]      GAP_LOAD   = (GAP > 0) ? 32'(GAP - 1) : 32'd0;

  typedef enum logic [2:0] {TX_IDLE, TX_HEAD, TX_BODY, TX_GAP, TX_DONE} tx_state_t;
  typedef enum logic {RX_WAIT_HEAD, RX_BODY} rx_state_t;

  // Row-major step over the mesh, X fastest; node ids are packed {y, x}.
  function automatic logic [7:0] step_node(input logic [7:0] p);
    logic [3:0] x;
    logic [3:0] y;
    x = p[3:0] + 4'd1;
    y = p[7:4];
    if (x == MX) begin
      x = 4'd0;
      y = y + 4'd1;
      if (y == MY) y = 4'd0;
    end
    return {y, x};
  endfunction

  function automatic logic [7:0] next_dest(input logic [7:0] p);
    logic [7:0] n;
    n = step_node(p);
    if (n == SELF_ID) n = step_node(n);
    return n;
  endfunction

  localparam logic [7:0] FIRST_DEST = (SELF_ID == 8'h00) ? step_node(8'h00) : 8'h00;

  tx_state_t        tx_state_q, tx_state_d;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       idx_q, idx_d;
  logic [31:0]      gap_cnt_q, gap_cnt_d;
  logic [7:0]       dest_q, dest_d;
  logic [CNT_W-1:0] tx_pkt_cnt_q, tx_pkt_cnt_d;

  rx_state_t        rx_state_q, rx_state_d;
  logic [7:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_seq_q, rx_seq_d;
  logic [7:0]       rx_len_q, rx_len_d;
  logic             rx_pkt_err_q, rx_pkt_err_d;
  logic [CNT_W-1:0] rx_pkt_cnt_q, rx_pkt_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             rx_ready_q;

  logic [DATA_WIDTH-1:0] hdr_flit;
  logic [DATA_WIDTH-1:0] body_flit;
  logic [DATA_WIDTH-1:0] exp_body;
  logic                  tail_hs;
  logic                  last_pkt;

  // TX next-state and sender outputs; fields depend only on state so they stay stable under backpressure.
  always_comb begin
    tx_state_d       = tx_state_q;
    seq_d            = seq_q;
    idx_d            = idx_q;
    gap_cnt_d        = gap_cnt_q;
    dest_d           = dest_q;
    tx_pkt_cnt_d     = tx_pkt_cnt_q;
    sender_valid     = 1'b0;
    sender_is_header = 1'b0;
    sender_is_tail   = 1'b0;
    sender_flit      = '0;
    tail_hs          = 1'b0;
    last_pkt         = 1'b0;
    hdr_flit         = '0;
    hdr_flit[31:0]   = {LEN_B, seq_q, SELF_ID, (MODE == 1) ? dest_q : FIXED_DEST};
    body_flit        = '0;
    body_flit[15:0]  = {seq_q, idx_q};
    case (tx_state_q)
      TX_IDLE: if (start) tx_state_d = TX_HEAD;
      TX_HEAD: begin
        sender_valid     = 1'b1;
        sender_is_header = 1'b1;
        sender_is_tail   = (PKT_LEN == 1);
        sender_flit      = hdr_flit;
        if (sender_ready) begin
          if (PKT_LEN == 1) begin
            tail_hs = 1'b1;
          end else begin
            idx_d      = 8'd1;
            tx_state_d = TX_BODY;
          end
        end
      end
      TX_BODY: begin
        sender_valid   = 1'b1;
        sender_is_tail = (idx_q == LAST_IDX);
        sender_flit    = body_flit;
        if (sender_ready) begin
          if (idx_q == LAST_IDX) tail_hs = 1'b1;
          else idx_d = idx_q + 8'd1;
        end
      end
      TX_GAP: begin
        if (NUM_PKTS != 0 && tx_pkt_cnt_q == NUM_PKTS_C) tx_state_d = TX_DONE;
        else if (gap_cnt_q == 32'd0) begin
          if (start) tx_state_d = TX_HEAD;
        end else gap_cnt_d = gap_cnt_q - 32'd1;
      end
      TX_DONE: tx_state_d = TX_DONE;
      default: tx_state_d = TX_IDLE;
    endcase
    if (tail_hs) begin
      seq_d        = seq_q + 8'd1;
      tx_pkt_cnt_d = (tx_pkt_cnt_q == CNT_MAX) ? tx_pkt_cnt_q : tx_pkt_cnt_q + CNT_W'(1);
      if (MODE == 1) dest_d = next_dest(dest_q);
      gap_cnt_d    = GAP_LOAD;
      last_pkt     = (NUM_PKTS != 0) && (tx_pkt_cnt_d == NUM_PKTS_C);
      // Back-to-back packets when there is no gap, so PKT_LEN = 1 streams one flit per cycle.
      tx_state_d   = (GAP == 0 && start && !last_pkt) ? TX_HEAD : TX_GAP;
    end
  end

  // RX checker: one error at most per accepted flit; a tail only counts if its packet was clean.
  always_comb begin
    logic acc, dest_bad, tail_bad, pay_bad, len_one, last, err, rx_inc;
    rx_state_d     = rx_state_q;
    rx_idx_d       = rx_idx_q;
    rx_seq_d       = rx_seq_q;
    rx_len_d       = rx_len_q;
    rx_pkt_err_d   = rx_pkt_err_q;
    exp_body       = '0;
    exp_body[15:0] = {rx_seq_q, rx_idx_q};
    acc      = receive_valid && rx_ready_q;
    dest_bad = (receive_flit[7:0] != SELF_ID);
    len_one  = (receive_flit[31:24] <= 8'd1);
    last     = (rx_idx_q == rx_len_q - 8'd1);
    pay_bad  = (receive_flit != exp_body);
    tail_bad = 1'b0;
    err      = 1'b0;
    rx_inc   = 1'b0;
    if (acc) begin
      if (receive_is_header) begin
        tail_bad     = len_one ? !receive_is_tail : receive_is_tail;
        err          = (rx_state_q == RX_BODY) || dest_bad || tail_bad;
        rx_seq_d     = receive_flit[23:16];
        rx_len_d     = receive_flit[31:24];
        rx_idx_d     = 8'd1;
        rx_pkt_err_d = dest_bad || tail_bad;
        if (len_one || receive_is_tail) begin
          rx_state_d = RX_WAIT_HEAD;
          rx_inc     = receive_is_tail && !rx_pkt_err_d;
        end else rx_state_d = RX_BODY;
      end else if (rx_state_q == RX_WAIT_HEAD) begin
        err = 1'b1;
      end else begin
        tail_bad     = last ? !receive_is_tail : receive_is_tail;
        err          = tail_bad || pay_bad;
        rx_pkt_err_d = rx_pkt_err_q || err;
        if (last || receive_is_tail) begin
          rx_state_d = RX_WAIT_HEAD;
          rx_inc     = receive_is_tail && !rx_pkt_err_d;
        end else rx_idx_d = rx_idx_q + 8'd1;
      end
    end
    rx_pkt_cnt_d = (rx_inc && rx_pkt_cnt_q != CNT_MAX) ? rx_pkt_cnt_q + CNT_W'(1) : rx_pkt_cnt_q;
    err_cnt_d    = (err && err_cnt_q != CNT_MAX) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      tx_state_q   <= TX_IDLE;
      seq_q        <= 8'd0;
      idx_q        <= 8'd0;
      gap_cnt_q    <= 32'd0;
      dest_q       <= FIRST_DEST;
      tx_pkt_cnt_q <= '0;
      rx_state_q   <= RX_WAIT_HEAD;
      rx_idx_q     <= 8'd0;
      rx_seq_q     <= 8'd0;
      rx_len_q     <= 8'd0;
      rx_pkt_err_q <= 1'b0;
      rx_pkt_cnt_q <= '0;
      err_cnt_q    <= '0;
      rx_ready_q   <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      seq_q        <= seq_d;
      idx_q        <= idx_d;
      gap_cnt_q    <= gap_cnt_d;
      dest_q       <= dest_d;
      tx_pkt_cnt_q <= tx_pkt_cnt_d;
      rx_state_q   <= rx_state_d;
      rx_idx_q     <= rx_idx_d;
      rx_seq_q     <= rx_seq_d;
      rx_len_q     <= rx_len_d;
      rx_pkt_err_q <= rx_pkt_err_d;
      rx_pkt_cnt_q <= rx_pkt_cnt_d;
      err_cnt_q    <= err_cnt_d;
      rx_ready_q   <= 1'b1;
    end
  end

  assign receive_ready = rx_ready_q;
  assign tx_pkt_cnt    = tx_pkt_cnt_q;
  assign rx_pkt_cnt    = rx_pkt_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign done          = (tx_state_q == TX_DONE);

endmodule
